// File: rtl/alloc_selftest_pkg.sv
// Shared types and the fixed test script for the allocator self-test.
package alloc_selftest_pkg;

  localparam int NIL       = 0;
  localparam int NUM_STEPS = 8;

  typedef enum logic [1:0] {OP_ALLOC, OP_FREE, OP_READ, OP_WRITE} op_e;

  // One script step; exp_val holds the expected address (alloc) or data (read).
  typedef struct packed {
    op_e         op;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [15:0] exp_val;
  } scr_t;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_DONE, S_FAIL} seq_state_e;
  typedef enum logic [1:0] {A_IDLE, A_READ, A_LINK} alloc_state_e;

  function automatic scr_t script_rom(input logic [2:0] idx);
    scr_t e;
    case (idx)
      3'd0:    e = '{OP_ALLOC, 8'h00, 16'h1234, 16'h0001};
      3'd1:    e = '{OP_ALLOC, 8'h00, 16'h5678, 16'h0002};
      3'd2:    e = '{OP_READ,  8'h01, 16'h0000, 16'h1234};
      3'd3:    e = '{OP_FREE,  8'h01, 16'h0000, 16'h0000};
      3'd4:    e = '{OP_ALLOC, 8'h00, 16'h9ABC, 16'h0001};
      3'd5:    e = '{OP_ALLOC, 8'h00, 16'hDEF0, 16'h0003};
      3'd6:    e = '{OP_READ,  8'h01, 16'h0000, 16'h9ABC};
      default: e = '{OP_READ,  8'h02, 16'h0000, 16'h5678};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/alloc_selftest_cell_alloc.sv
// Cell allocator: bump pointer plus a LIFO free list threaded through the cells.
module cell_alloc
  import alloc_selftest_pkg::*;
#(
  parameter int ADDR_SZ = 8,
  parameter int DATA_SZ = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_vld,
  input  op_e                req_op,
  input  logic [ADDR_SZ-1:0] req_addr,
  input  logic [DATA_SZ-1:0] req_data,
  output logic               done,
  output logic [ADDR_SZ-1:0] rsp_addr,
  output logic [DATA_SZ-1:0] rsp_data,
  output logic               full
);

  logic [DATA_SZ-1:0] mem [2**ADDR_SZ];
  logic [DATA_SZ-1:0] rdata, pend_data;
  logic [DATA_SZ-1:0] wd;
  logic [ADDR_SZ-1:0] wa, ra;
  logic               we;

  alloc_state_e       st, st_n;
  logic [ADDR_SZ-1:0] next_unused, nu_n, free_head, fh_n, addr_n;
  logic [DATA_SZ-1:0] data_n;
  logic               full_n, done_n;

  // Single-port-style RAM, one cycle read latency, read-old on collision.
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    rdata <= mem[ra];
  end

  // Next-state: free-list pops read the link first, then write the new data.
  always_comb begin
    st_n   = st;
    nu_n   = next_unused;
    fh_n   = free_head;
    full_n = full;
    done_n = 1'b0;
    addr_n = rsp_addr;
    data_n = rsp_data;
    we     = 1'b0;
    wa     = req_addr;
    wd     = req_data;
    ra     = req_addr;
    case (st)
      A_IDLE: if (req_vld) begin
        case (req_op)
          OP_ALLOC: begin
            if (free_head != ADDR_SZ'(NIL)) begin
              ra   = free_head;
              st_n = A_LINK;
            end else if (&next_unused) begin
              full_n = 1'b1;
              addr_n = ADDR_SZ'(NIL);
              done_n = 1'b1;
            end else begin
              we     = 1'b1;
              wa     = next_unused;
              addr_n = next_unused;
              nu_n   = next_unused + 1'b1;
              done_n = 1'b1;
            end
          end
          OP_FREE: begin
            if (req_addr != ADDR_SZ'(NIL)) begin
              we   = 1'b1;
              wd   = DATA_SZ'(free_head);
              fh_n = req_addr;
            end
            done_n = 1'b1;
          end
          OP_READ: st_n = A_READ;
          default: begin
            we     = 1'b1;
            done_n = 1'b1;
          end
        endcase
      end
      A_READ: begin
        data_n = rdata;
        done_n = 1'b1;
        st_n   = A_IDLE;
      end
      A_LINK: begin
        we     = 1'b1;
        wa     = free_head;
        wd     = pend_data;
        addr_n = free_head;
        fh_n   = ADDR_SZ'(rdata);
        done_n = 1'b1;
        st_n   = A_IDLE;
      end
      default: st_n = A_IDLE;
    endcase
  end

  // Control/state registers and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= A_IDLE;
      next_unused <= ADDR_SZ'(1);
      free_head   <= ADDR_SZ'(NIL);
      full        <= 1'b0;
      done        <= 1'b0;
      rsp_addr    <= '0;
      rsp_data    <= '0;
      pend_data   <= '0;
    end else begin
      st          <= st_n;
      next_unused <= nu_n;
      free_head   <= fh_n;
      full        <= full_n;
      done        <= done_n;
      rsp_addr    <= addr_n;
      rsp_data    <= data_n;
      if (st == A_IDLE && req_vld) pend_data <= req_data;
    end
  end

endmodule

// File: rtl/alloc_selftest.sv
// Scripted sequencer driving one cell allocator and checking its results.
module alloc_selftest
  import alloc_selftest_pkg::*;
#(
  parameter int ADDR_SZ   = 8,
  parameter int DATA_SZ   = 16,
  parameter bit FAULT_INJ = 1'b0  // corrupts step 6 expectation to exercise FAIL
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  output logic        o_running,
  output logic [15:0] o_debug,
  output logic        o_passed,
  output logic        o_error
);

  seq_state_e         st, st_n;
  logic [7:0]         step, step_n, last, last_n, res_byte;
  logic               run_n, pass_n, err_n, got, match, req_vld;
  logic [15:0]        exp_v;
  scr_t               ent;

  logic               a_done, a_full;
  logic [ADDR_SZ-1:0] a_addr;
  logic [DATA_SZ-1:0] a_data;

  assign ent     = script_rom(step[2:0]);
  assign o_debug = {step, last};

  cell_alloc #(.ADDR_SZ(ADDR_SZ), .DATA_SZ(DATA_SZ)) u_alloc (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .req_vld  (req_vld),
    .req_op   (ent.op),
    .req_addr (ADDR_SZ'(ent.addr)),
    .req_data (DATA_SZ'(ent.data)),
    .done     (a_done),
    .rsp_addr (a_addr),
    .rsp_data (a_data),
    .full     (a_full)
  );

  // Compare the held allocator result against the current step's expectation.
  always_comb begin
    exp_v = ent.exp_val;
    if (FAULT_INJ && step == 8'd6) exp_v = ~exp_v;
    match    = 1'b1;
    res_byte = last;
    case (ent.op)
      OP_ALLOC: begin
        match    = !a_full && (a_addr == ADDR_SZ'(exp_v));
        res_byte = 8'(a_addr);
      end
      OP_READ: begin
        match    = (a_data == DATA_SZ'(exp_v));
        res_byte = a_data[7:0];
      end
      default: ;
    endcase
  end

  // Sequencer next-state; everything freezes while i_en is low.
  always_comb begin
    st_n    = st;
    step_n  = step;
    last_n  = last;
    run_n   = o_running;
    pass_n  = o_passed;
    err_n   = o_error;
    req_vld = 1'b0;
    if (i_en) begin
      case (st)
        S_IDLE: begin
          st_n  = S_ISSUE;
          run_n = 1'b1;
        end
        S_ISSUE: begin
          req_vld = 1'b1;
          st_n    = S_WAIT;
        end
        S_WAIT: if (got || a_done) st_n = S_CHECK;
        S_CHECK: begin
          last_n = res_byte;
          if (!match) begin
            st_n  = S_FAIL;
            err_n = 1'b1;
            run_n = 1'b0;
          end else if (step == 8'(NUM_STEPS - 1)) begin
            st_n   = S_DONE;
            pass_n = 1'b1;
            run_n  = 1'b0;
          end else begin
            step_n = step + 8'd1;
            st_n   = S_ISSUE;
          end
        end
        default: ;
      endcase
    end
  end

  // Sequencer registers; got remembers a done pulse that arrived while paused.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st        <= S_IDLE;
      step      <= '0;
      last      <= '0;
      o_running <= 1'b0;
      o_passed  <= 1'b0;
      o_error   <= 1'b0;
      got       <= 1'b0;
    end else begin
      st        <= st_n;
      step      <= step_n;
      last      <= last_n;
      o_running <= run_n;
      o_passed  <= pass_n;
      o_error   <= err_n;
      if (req_vld)     got <= 1'b0;
      else if (a_done) got <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alloc_selftest.sv
// Randomized-enable bench for alloc_selftest with an abstract allocator model.
module tb_alloc_selftest;

  logic        clk = 1'b0;
  logic        rst_n, en;
  logic        run_a, pass_a, err_a, run_b, pass_b, err_b;
  logic [15:0] dbg_a, dbg_b, prev_dbg;
  int          n_chk = 0, n_fail = 0, cyc;

  // Script copy: op 0=alloc, 1=free, 2=read.
  int t_op   [8] = '{0, 0, 2, 1, 0, 0, 2, 2};
  int t_addr [8] = '{0, 0, 1, 1, 0, 0, 1, 2};
  int t_data [8] = '{'h1234, 'h5678, 0, 0, 'h9ABC, 'hDEF0, 0, 0};

  logic [15:0] exp_trace[$], obs[$];
  logic [7:0]  exp_fail_low;
  int          exp_free_head;

  always #5 clk = ~clk;

  alloc_selftest #(.ADDR_SZ(8), .DATA_SZ(16), .FAULT_INJ(1'b0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
    .o_running(run_a), .o_debug(dbg_a), .o_passed(pass_a), .o_error(err_a));

  alloc_selftest #(.ADDR_SZ(8), .DATA_SZ(16), .FAULT_INJ(1'b1)) dut_f (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
    .o_running(run_b), .o_debug(dbg_b), .o_passed(pass_b), .o_error(err_b));

  // Record every new nonzero debug value as the step trace.
  always @(negedge clk) begin
    if (dbg_a != prev_dbg && dbg_a != 16'h0) obs.push_back(dbg_a);
    prev_dbg <= dbg_a;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Allocator as a bump counter plus a LIFO list of freed cells.
  task automatic build_model();
    logic [15:0] cells [256];
    int          nxt = 1;
    int          fl[$];
    int          a, stp, d;
    logic [7:0]  last = 8'h0;
    for (int i = 0; i < 8; i++) begin
      case (t_op[i])
        0: begin
          if (fl.size() > 0) a = fl.pop_back();
          else begin a = nxt; nxt++; end
          d = t_data[i];
          cells[a] = d[15:0];
          last = a[7:0];
        end
        1: if (t_addr[i] != 0) fl.push_back(t_addr[i]);
        default: last = cells[t_addr[i]][7:0];
      endcase
      if (i == 6) exp_fail_low = last;
      stp = (i == 7) ? 7 : i + 1;
      exp_trace.push_back({stp[7:0], last});
    end
    exp_free_head = (fl.size() == 0) ? 0 : fl[fl.size()-1];
  endtask

  task automatic drive(input bit rnd, input bit pause, input int stop_step, output int n);
    logic [15:0] hold;
    bit          paused = 1'b0;
    n = 0;
    while (!(pass_a || err_a) && n < 400) begin
      if (stop_step >= 0 && int'(dbg_a[15:8]) == stop_step) break;
      if (pause && !paused && dbg_a[15:8] == 8'd2) begin
        hold = dbg_a;
        en   = 1'b0;
        repeat (5) @(negedge clk);
        chk("pause_hold", 32'(dbg_a), 32'(hold));
        chk("pause_running", 32'(run_a), 32'd1);
        paused = 1'b1;
      end
      en = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic start(input string tag);
    obs.delete();
    en = 1'b1;
    @(negedge clk);
    chk({tag, "_running_rise"}, 32'(run_a), 32'd1);
  endtask

  task automatic check_pass(input string tag);
    #1;
    chk({tag, "_finished"}, 32'(pass_a || err_a), 32'd1);
    chk({tag, "_passed"},   32'(pass_a), 32'd1);
    chk({tag, "_error"},    32'(err_a),  32'd0);
    chk({tag, "_running"},  32'(run_a),  32'd0);
    chk({tag, "_debug"},    32'(dbg_a),  32'h0778);
    chk({tag, "_trace_len"}, 32'(obs.size()), 32'(exp_trace.size()));
    for (int i = 0; i < exp_trace.size(); i++)
      chk($sformatf("%s_trace%0d", tag, i),
          32'((i < obs.size()) ? obs[i] : 16'hxxxx), 32'(exp_trace[i]));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_running"}, 32'(run_a),  32'd0);
    chk({tag, "_passed"},  32'(pass_a), 32'd0);
    chk({tag, "_error"},   32'(err_a),  32'd0);
    chk({tag, "_debug"},   32'(dbg_a),  32'd0);
  endtask

  task automatic do_reset();
    en    = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    build_model();
    repeat (3) @(negedge clk);
    chk_zero("in_reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("idle_en_low");

    // Full-speed run; also observes the fault-injected copy.
    start("A");
    drive(1'b0, 1'b0, -1, cyc);
    chk("A_cycles_le_40", 32'(cyc <= 40), 32'd1);
    check_pass("A");
    chk("A_free_head_nil", 32'(dut.u_alloc.free_head), 32'(exp_free_head));
    chk("F_error",   32'(err_b),  32'd1);
    chk("F_passed",  32'(pass_b), 32'd0);
    chk("F_running", 32'(run_b),  32'd0);
    chk("F_debug",   32'(dbg_b),  32'({8'h06, exp_fail_low}));
    repeat (5) @(negedge clk);
    chk("F_debug_stable", 32'(dbg_b), 32'({8'h06, exp_fail_low}));
    chk("A_no_restart", 32'({pass_a, dbg_a}), 32'({1'b1, 16'h0778}));

    // Random enable with a forced 5-cycle pause during step 2.
    do_reset();
    start("B");
    drive(1'b1, 1'b1, -1, cyc);
    check_pass("B");

    // Async reset mid-script, then rerun from step 0.
    do_reset();
    start("C");
    drive(1'b1, 1'b0, 3, cyc);
    chk("C_reached_step3", 32'(dbg_a[15:8]), 32'd3);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    @(negedge clk);
    en    = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    start("D");
    drive(1'b1, 1'b0, -1, cyc);
    check_pass("D");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
